// File: rtl/mmm_pkg.sv
// Shared core package: machine widths and the instruction-queue entry type.
package mmm_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned IQ_DEPTH = 8;

  // One buffered fetch beat.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/iq_ptr_ctrl.sv
// Pointer, occupancy and full/empty bookkeeping for instr_queue.
// Full/empty come from the occupancy count, so pointers may wrap freely.
module iq_ptr_ctrl import mmm_pkg::*; #(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W-1:0] PtrOne  = 1;
  localparam logic [PTR_W:0]   CntOne  = 1;
  localparam logic [PTR_W:0]   CntFull = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Next-state: flush wins over any handshake in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Occupancy decode.
  always_comb begin
    wr_ptr = wr_ptr_q;
    rd_ptr = rd_ptr_q;
    count  = count_q;
    full   = (count_q == CntFull);
    empty  = (count_q == '0);
  end

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode decoupling FIFO with single-cycle flush.
// Optional macro INSTR_QUEUE_BYPASS_EN adds a zero-latency path when empty.
module instr_queue import mmm_pkg::*; #(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  input  logic [ILEN-1:0] fetch_instr_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            fetch_ready_o,
  input  logic            decode_ready_i,
  output logic            decode_valid_o,
  output logic [ILEN-1:0] decode_instr_o,
  output logic [XLEN-1:0] decode_pc_o,
  output logic [PTR_W:0]  count_o
);

  iq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty;
  logic             bypass_hit;
  logic             push_fire, pop_fire;

  iq_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr_ctrl (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush   (flush_i),
    .push    (push_fire),
    .pop     (pop_fire),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .count   (count_o),
    .full    (full),
    .empty   (empty)
  );

  // Handshake decode; a bypassed beat taken by decode touches no state.
  always_comb begin
`ifdef INSTR_QUEUE_BYPASS_EN
    bypass_hit = empty & fetch_valid_i & ~flush_i;
`else
    bypass_hit = 1'b0;
`endif
    fetch_ready_o  = ~full;
    decode_valid_o = (~empty | bypass_hit) & ~flush_i;
    pop_fire       = ~empty & decode_ready_i & ~flush_i;
    push_fire      = fetch_valid_i & ~full & ~flush_i & ~(bypass_hit & decode_ready_i);
  end

  // Entry storage; flush leaves contents in place.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_fire) begin
      mem_q[wr_ptr] <= '{pc: fetch_pc_i, instr: fetch_instr_i};
    end
  end

  // Head mux, zeroed whenever nothing valid is presented.
  always_comb begin
    decode_instr_o = '0;
    decode_pc_o    = '0;
    if (decode_valid_o) begin
      if (bypass_hit) begin
        decode_instr_o = fetch_instr_i;
        decode_pc_o    = fetch_pc_i;
      end else begin
        decode_instr_o = mem_q[rd_ptr].instr;
        decode_pc_o    = mem_q[rd_ptr].pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_instr_queue;
  import mmm_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            fvalid = 1'b0;
  logic [ILEN-1:0] finstr = '0;
  logic [XLEN-1:0] fpc = '0;
  logic            fready;
  logic            dready = 1'b0;
  logic            dvalid;
  logic [ILEN-1:0] dinstr;
  logic [XLEN-1:0] dpc;
  logic [3:0]      count;

  int checks = 0;
  int failures = 0;

  // Behavioural model: plain ordered list of buffered beats.
  iq_entry_t mq[$];

  // Outputs sampled mid-cycle by the last step.
  logic            s_rdy, s_val;
  logic [ILEN-1:0] s_instr;
  logic [XLEN-1:0] s_pc;
  logic [3:0]      s_cnt;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .flush_i        (flush),
    .fetch_valid_i  (fvalid),
    .fetch_instr_i  (finstr),
    .fetch_pc_i     (fpc),
    .fetch_ready_o  (fready),
    .decode_ready_i (dready),
    .decode_valid_o (dvalid),
    .decode_instr_o (dinstr),
    .decode_pc_o    (dpc),
    .count_o        (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, advance model at posedge.
  task automatic step(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic dr, input logic fl);
    logic      e_rdy, e_val;
    bit        byp;
    iq_entry_t e_head;
    @(negedge clk);
    fvalid = fv; finstr = ins; fpc = pc; dready = dr; flush = fl;
    #2;
    s_rdy = fready; s_val = dvalid; s_instr = dinstr; s_pc = dpc; s_cnt = count;
    e_rdy = (mq.size() != DEPTH);
    byp = 0;
`ifdef INSTR_QUEUE_BYPASS_EN
    byp = (mq.size() == 0) && fv && !fl;
`endif
    e_val = ((mq.size() != 0) || byp) && !fl;
    e_head = '0;
    if (e_val) e_head = (mq.size() != 0) ? mq[0] : '{pc: pc, instr: ins};
    chk("m_ready", {63'd0, s_rdy}, {63'd0, e_rdy});
    chk("m_valid", {63'd0, s_val}, {63'd0, e_val});
    chk("m_instr", {32'd0, s_instr}, {32'd0, e_head.instr});
    chk("m_pc", {32'd0, s_pc}, {32'd0, e_head.pc});
    chk("m_count", {60'd0, s_cnt}, 64'(mq.size()));
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else if (!(byp && dr)) begin
      if (e_val && dr) void'(mq.pop_front());
      if (fv && e_rdy) mq.push_back('{pc: pc, instr: ins});
    end
  endtask

  typedef struct {
    logic        fv;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        dr;
    logic        fl;
    logic        e_rdy;
    logic        e_val;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vt[7];

  initial begin
    // Three pushes with decode stalled, then three pops.
    vt[0] = '{1, 32'h00000013, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0, 0};
`ifdef INSTR_QUEUE_BYPASS_EN
    vt[0] = '{1, 32'h00000013, 32'h0, 0, 0, 1, 1, 32'h00000013, 32'h0, 0};
`endif
    vt[1] = '{1, 32'h00100093, 32'h4, 0, 0, 1, 1, 32'h00000013, 32'h0, 1};
    vt[2] = '{1, 32'h00200113, 32'h8, 0, 0, 1, 1, 32'h00000013, 32'h0, 2};
    vt[3] = '{0, 32'h0,        32'h0, 1, 0, 1, 1, 32'h00000013, 32'h0, 3};
    vt[4] = '{0, 32'h0,        32'h0, 1, 0, 1, 1, 32'h00100093, 32'h4, 2};
    vt[5] = '{0, 32'h0,        32'h0, 1, 0, 1, 1, 32'h00200113, 32'h8, 1};
    vt[6] = '{0, 32'h0,        32'h0, 1, 0, 1, 0, 32'h0,        32'h0, 0};

    // Reset state.
    #12;
    chk("rst_valid", {63'd0, dvalid}, 64'd0);
    chk("rst_ready", {63'd0, fready}, 64'd1);
    chk("rst_count", {60'd0, count}, 64'd0);
    chk("rst_instr", {32'd0, dinstr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      step(vt[i].fv, vt[i].ins, vt[i].pc, vt[i].dr, vt[i].fl);
      chk($sformatf("vec%0d_ready", i), {63'd0, s_rdy}, {63'd0, vt[i].e_rdy});
      chk($sformatf("vec%0d_valid", i), {63'd0, s_val}, {63'd0, vt[i].e_val});
      chk($sformatf("vec%0d_instr", i), {32'd0, s_instr}, {32'd0, vt[i].e_ins});
      chk($sformatf("vec%0d_pc", i), {32'd0, s_pc}, {32'd0, vt[i].e_pc});
      chk($sformatf("vec%0d_count", i), {60'd0, s_cnt}, {60'd0, vt[i].e_cnt});
    end

    // Fill, refused push at full even with a pop, then accepted push.
    for (int i = 0; i < 8; i++) step(1, 32'h1000 + i, 32'(i * 4), 0, 0);
    step(1, 32'h2020, 32'h20, 0, 0);
    chk("full_ready", {63'd0, s_rdy}, 64'd0);
    chk("full_count", {60'd0, s_cnt}, 64'd8);
    step(1, 32'h2020, 32'h20, 1, 0);
    chk("full_pop_pc", {32'd0, s_pc}, 64'h0);
    step(1, 32'h2020, 32'h20, 0, 0);
    chk("refused_count", {60'd0, s_cnt}, 64'd7);
    chk("refused_ready", {63'd0, s_rdy}, 64'd1);
    step(0, 0, 0, 0, 0);
    chk("refill_count", {60'd0, s_cnt}, 64'd8);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("drain_count", {60'd0, s_cnt}, 64'd0);

    // Steady push+pop across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      step(1, 32'h3000 + i, 32'(i * 4), (i != 0), 0);
      if (i != 0) chk($sformatf("steady%0d_count", i), {60'd0, s_cnt}, 64'd1);
    end
    step(0, 0, 0, 1, 0);
    chk("steady_last_pc", {32'd0, s_pc}, 64'h4C);

    // Flush with a concurrent fetch beat.
    for (int i = 0; i < 5; i++) step(1, 32'h4000 + i, 32'h200 + 32'(i * 4), 0, 0);
    step(1, 32'h4100, 32'h100, 0, 1);
    chk("flush_valid", {63'd0, s_val}, 64'd0);
    chk("flush_count_pre", {60'd0, s_cnt}, 64'd5);
    step(0, 0, 0, 1, 0);
    chk("flush_count_post", {60'd0, s_cnt}, 64'd0);
    chk("flush_dropped", {63'd0, s_val}, 64'd0);
    step(0, 0, 0, 1, 0);
    chk("flush_dropped2", {63'd0, s_val}, 64'd0);

`ifdef INSTR_QUEUE_BYPASS_EN
    step(1, 32'h5555, 32'h40, 1, 0);
    chk("byp_valid", {63'd0, s_val}, 64'd1);
    chk("byp_pc", {32'd0, s_pc}, 64'h40);
    step(0, 0, 0, 0, 0);
    chk("byp_count", {60'd0, s_cnt}, 64'd0);
`endif

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) step(1, 32'h6000 + i, 32'h300 + 32'(i * 4), 0, 0);
    @(negedge clk);
    fvalid = 1'b0; dready = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_count", {60'd0, count}, 64'd0);
    chk("arst_valid", {63'd0, dvalid}, 64'd0);
    chk("arst_ready", {63'd0, fready}, 64'd1);
    mq.delete();
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom, $urandom & 32'hFFFF_FFFC,
           ($urandom_range(0, 9) < 5), ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
